// File: rtl/seg_pkg.sv
// seg_pkg: shared glyph table, scan state encoding and width helpers for seg_scan_ctrl
package seg_pkg;
  typedef enum logic [1:0] {IDLE, GAP, ON} state_t;
  // {a,b,c,d,e,f,g} active-high, entry 15 first
  localparam logic [15:0][6:0] GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display data inputs and digit/segment outputs of the scanner
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 4, parameter int BRIGHT_W = 3);
  logic [4*NUM_DIGITS-1:0] bcd_int;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    hex_mode;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   digit;
  logic [7:0]              seg;
  logic                    frame_done;
  modport master(output bcd_int, dp_mask, blank_lz, hex_mode, brightness, input digit, seg, frame_done);
  modport slave(input bcd_int, dp_mask, blank_lz, hex_mode, brightness, output digit, seg, frame_done);
endinterface

// File: rtl/seg_tick_edge.sv
// seg_tick_edge: synchronise the slow scan clock and emit a one-cycle pulse per rising edge
module seg_tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic scan_pulse
);
  logic [1:0] sync_q, sync_d;
  logic       edge_q, edge_d, pulse_q, pulse_d;
  always_comb begin
    sync_d  = {sync_q[0], tick_in};
    edge_d  = sync_q[1];
    pulse_d = sync_q[1] & ~edge_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
    end
  end
  assign scan_pulse = pulse_q;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed N-digit 7-segment scanner with frame snapshot, blanking, PWM and dead time
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int BRIGHT_W         = 3,
  parameter int GAP_CYCLES       = 16
) (
  input  logic            fpga_clk,
  input  logic            sys_init_ctrl,
  input  logic            clk_1KHz,
  seg_scan_ctrl_if.slave  bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIGIT_ACTIVE_LOW != 0 ? '1 : '0;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [BRIGHT_W-1:0]     pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, lz;
  logic                    blz_q, blz_d, hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic [7:0]              seg_q, seg_d;
  logic                    fd_q, fd_d;
  logic                    scan_pulse, load, enter_on, zero_run;
  logic [3:0]              nib;
  logic [6:0]              glyph;
  seg_tick_edge u_tick (
    .clk        (fpga_clk),
    .rst        (sys_init_ctrl),
    .tick_in    (clk_1KHz),
    .scan_pulse (scan_pulse)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    pwm_d   = pwm_q + 1'b1;
    load    = 1'b0;
    if (scan_pulse && state_q != GAP) begin
      idx_d   = (state_q == IDLE || idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      load    = idx_d == '0;
      state_d = GAP_CYCLES == 0 ? ON : GAP;
      gap_d   = '0;
    end else if (state_q == GAP) begin
      state_d = gap_q == GW'(GAP_CYCLES - 1) ? ON : GAP;
      gap_d   = gap_q + 1'b1;
    end
    bcd_d = load ? bus.bcd_int  : bcd_q;
    dp_d  = load ? bus.dp_mask  : dp_q;
    blz_d = load ? bus.blank_lz : blz_q;
    hex_d = load ? bus.hex_mode : hex_q;
    // a digit is blanked while every nibble from the top down to it is zero
    lz       = '0;
    zero_run = blz_d;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run && bcd_d[4*k +: 4] == 4'd0;
      lz[k]    = zero_run;
    end
    nib      = bcd_d[{idx_d, 2'b00} +: 4];
    glyph    = (lz[idx_d] || (nib > 4'd9 && !hex_d)) ? 7'd0 : GLYPHS[nib];
    enter_on = state_d == ON && (state_q != ON || scan_pulse);
    digit_d  = (state_d == ON && pwm_d <= bus.brightness) ? DIG_OFF ^ (NUM_DIGITS'(1) << idx_d) : DIG_OFF;
    seg_d    = state_d == ON ? SEG_OFF ^ {glyph, dp_d[idx_d]} : SEG_OFF;
    fd_d     = enter_on && idx_d == IW'(NUM_DIGITS - 1);
  end
  always_ff @(posedge fpga_clk) begin
    if (sys_init_ctrl) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      pwm_q   <= '0;
      bcd_q   <= '0;
      dp_q    <= '0;
      blz_q   <= 1'b0;
      hex_q   <= 1'b0;
      digit_q <= DIG_OFF;
      seg_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      pwm_q   <= pwm_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      blz_q   <= blz_d;
      hex_q   <= hex_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end
  assign bus.digit      = digit_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, glyphs, blanking, snapshot, PWM and reset
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  seg_scan_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_W(3)) bus ();
  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1), .BRIGHT_W(3), .GAP_CYCLES(16)
  ) dut (
    .fpga_clk      (clk),
    .sys_init_ctrl (rst),
    .clk_1KHz      (tick),
    .bus           (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic slot(input string tag, input int k, input logic [7:0] es, input int eg, input logic efd);
    int  cnt = 0;
    int  n = 0;
    logic [3:0] ed;
    ed   = 4'hF ^ (4'd1 << k);
    tick = 1'b1;
    do begin @(negedge clk); n++; end while (bus.digit !== 4'hF && n < 100);
    cnt = 1;
    do begin @(negedge clk); cnt++; n++; end while (bus.digit === 4'hF && n < 200);
    cnt--;
    if (n >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
    chk({tag, "_digit"}, 32'(bus.digit), 32'(ed));
    chk({tag, "_seg"}, 32'(bus.seg), 32'(es));
    chk({tag, "_fd"}, 32'(bus.frame_done), 32'(efd));
    if (eg >= 0) chk({tag, "_gap"}, 32'(cnt), 32'(eg));
    repeat (5) @(negedge clk);
    tick = 1'b0;
    repeat (20) @(negedge clk);
  endtask
  task automatic count_on(input string tag, input int exp);
    int on = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.digit !== 4'hF) begin
        on++;
        chk({tag, "_onehot"}, 32'(bus.digit), 32'hE);
      end
    end
    chk({tag, "_cnt"}, 32'(on), 32'(exp));
  endtask
  initial begin
    int fd0;
    bus.bcd_int    = 16'h1234;
    bus.dp_mask    = 4'b0010;
    bus.blank_lz   = 1'b0;
    bus.hex_mode   = 1'b0;
    bus.brightness = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst_digit", 32'(bus.digit), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    fd0 = fd_cnt;
    slot("t1_d0", 0, 8'h99, 19, 1'b0);
    slot("t1_d1", 1, 8'h0C, 16, 1'b0);
    slot("t1_d2", 2, 8'h25, 16, 1'b0);
    slot("t1_d3", 3, 8'h9F, 16, 1'b1);
    chk("t1_fd_count", 32'(fd_cnt - fd0), 32'd1);
    bus.bcd_int  = 16'h0070;
    bus.dp_mask  = 4'b0000;
    bus.blank_lz = 1'b1;
    slot("t2_d0", 0, 8'h03, 16, 1'b0);
    slot("t2_d1", 1, 8'h1F, 16, 1'b0);
    slot("t2_d2", 2, 8'hFF, 16, 1'b0);
    slot("t2_d3", 3, 8'hFF, 16, 1'b1);
    bus.blank_lz = 1'b0;
    slot("t2n_d0", 0, 8'h03, 16, 1'b0);
    slot("t2n_d1", 1, 8'h1F, 16, 1'b0);
    slot("t2n_d2", 2, 8'h03, 16, 1'b0);
    slot("t2n_d3", 3, 8'h03, 16, 1'b1);
    bus.bcd_int  = 16'hABCF;
    bus.hex_mode = 1'b1;
    slot("t3_d0", 0, 8'h71, 16, 1'b0);
    bus.hex_mode = 1'b0;
    slot("t3_d1", 1, 8'h63, 16, 1'b0);
    slot("t3_d2", 2, 8'hC1, 16, 1'b0);
    slot("t3_d3", 3, 8'h11, 16, 1'b1);
    slot("t3n_d0", 0, 8'hFF, 16, 1'b0);
    slot("t3n_d1", 1, 8'hFF, 16, 1'b0);
    slot("t3n_d2", 2, 8'hFF, 16, 1'b0);
    slot("t3n_d3", 3, 8'hFF, 16, 1'b1);
    bus.bcd_int = 16'h1111;
    slot("t4_d0", 0, 8'h9F, 16, 1'b0);
    slot("t4_d1", 1, 8'h9F, 16, 1'b0);
    bus.bcd_int = 16'h2222;
    slot("t4_d2", 2, 8'h9F, 16, 1'b0);
    slot("t4_d3", 3, 8'h9F, 16, 1'b1);
    slot("t4n_d0", 0, 8'h25, 16, 1'b0);
    bus.brightness = 3'd0;
    count_on("t5_b0", 2);
    bus.brightness = 3'd7;
    count_on("t5_b7", 16);
    slot("t4n_d1", 1, 8'h25, 16, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_digit", 32'(bus.digit), 32'hF);
    chk("t6_seg", 32'(bus.seg), 32'hFF);
    chk("t6_fd", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    bus.bcd_int = 16'h5678;
    repeat (5) @(negedge clk);
    slot("t6_d0", 0, 8'h01, 19, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
